// File: rtl/seq_detector_param_if.sv
// Configuration, serial-bit and status signals of the programmable sequence detector.
// The testbench/host drives through master; the detector core attaches as slave.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               overlap_en;
  logic               data_valid;
  logic               data_in;
  logic               clr_count;
  logic               detected;
  logic [LEN_W-1:0]   state_out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, overlap_en, data_valid, data_in, clr_count,
    input  detected, state_out, match_count, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, overlap_en, data_valid, data_in, clr_count,
    output detected, state_out, match_count, cfg_err
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-programmable 1..MAX_LEN bit pattern; state k is the matched-prefix length.
// detected is a decode of registered state (one cycle after the completing bit); no backpressure, bits consumed on data_valid.
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_0101,
  parameter int                 DEFAULT_LEN     = 4
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_k;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_full;
  logic               w_cfg_ok;
  logic [LEN_W-1:0]   w_base_k;
  logic [LEN_W-1:0]   w_next_k;
  logic               w_hit;
  int                 w_best;
  int                 w_idx;
  logic               w_ok;
  logic               w_sbit;

  assign w_full   = (r_k == r_len);
  assign w_cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
    end else if (bus.cfg_load) begin
      if (w_cfg_ok) r_k <= '0;
    end else if (bus.data_valid) begin
      r_k <= w_next_k;
    end
  end

  // Next state: the candidate string is pattern[0..base-1] followed by the new bit;
  // the longest pattern prefix (<= len) that is a suffix of it wins. Non-overlap FULL restarts from empty.
  always_comb begin
    w_base_k = (w_full && !bus.overlap_en) ? '0 : r_k;
    w_best   = 0;
    w_idx    = 0;
    w_ok     = 1'b0;
    w_sbit   = 1'b0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if ((j <= int'(w_base_k) + 1) && (j <= int'(r_len))) begin
        w_ok = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < j) begin
            w_idx = int'(w_base_k) + 1 - j + i;
            if (w_idx == int'(w_base_k)) begin
              w_sbit = bus.data_in;
            end else if (w_idx < MAX_LEN) begin
              w_sbit = r_pattern[w_idx];
            end else begin
              w_sbit = 1'b0;
            end
            if (w_sbit != r_pattern[i]) w_ok = 1'b0;
          end
        end
        if (w_ok) w_best = j;
      end
    end
    w_next_k = LEN_W'(w_best);
  end

  // Outputs: pure decode of registered state
  always_comb begin
    bus.detected    = w_full;
    bus.state_out   = r_k;
    bus.match_count = r_cnt;
    bus.cfg_err     = r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= DEFAULT_PATTERN;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_err     <= 1'b0;
    end else if (bus.cfg_load) begin
      if (w_cfg_ok) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= bus.cfg_len;
        r_err     <= 1'b0;
      end else begin
        r_err     <= 1'b1;
      end
    end
  end

  // A hit is any accepted bit that lands in FULL, including FULL -> FULL
  assign w_hit = bus.data_valid && !bus.cfg_load && (w_next_k == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (bus.clr_count) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives two detectors (8-bit and 2-bit match counters) with identical directed and random traffic,
// checking every cycle against a model that searches the raw bit history for the longest matching pattern prefix.
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       t_ld, t_v, t_b, t_ov, t_clr;
  logic [7:0] t_pat;
  logic [3:0] t_len;

  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

  assign bus8.cfg_load = t_ld;   assign bus2.cfg_load = t_ld;
  assign bus8.cfg_pattern = t_pat; assign bus2.cfg_pattern = t_pat;
  assign bus8.cfg_len = t_len;   assign bus2.cfg_len = t_len;
  assign bus8.overlap_en = t_ov; assign bus2.overlap_en = t_ov;
  assign bus8.data_valid = t_v;  assign bus2.data_valid = t_v;
  assign bus8.data_in = t_b;     assign bus2.data_in = t_b;
  assign bus8.clr_count = t_clr; assign bus2.clr_count = t_clr;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: history of accepted bits (newest at bit 0) since the last restart.
  bit [31:0] m_hist;
  int        m_hlen;
  bit [7:0]  m_pat;
  int        m_len;
  int        m_cnt8, m_cnt2;
  bit        m_err;

  function automatic int mk();
    int best = 0;
    for (int j = 1; j <= m_len; j++) begin
      bit ok = (j <= m_hlen);
      for (int i = 0; i < j; i++)
        if (m_hist[j-1-i] != m_pat[i]) ok = 0;
      if (ok) best = j;
    end
    return best;
  endfunction

  task automatic model_reset();
    m_hist = '0; m_hlen = 0; m_pat = 8'h05; m_len = 4;
    m_cnt8 = 0; m_cnt2 = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit hit = 0;
    if (t_ld) begin
      if (t_len >= 1 && t_len <= 8) begin
        m_pat = t_pat; m_len = int'(t_len); m_hist = '0; m_hlen = 0; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (t_v) begin
      if (mk() == m_len && !t_ov) begin m_hist = '0; m_hlen = 0; end
      m_hist = {m_hist[30:0], t_b};
      if (m_hlen < 32) m_hlen++;
      hit = (mk() == m_len);
    end
    if (t_clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".k"},    int'(bus8.state_out),   mk());
    chk({tag, ".det"},  int'(bus8.detected),    int'(mk() == m_len));
    chk({tag, ".cnt8"}, int'(bus8.match_count), m_cnt8);
    chk({tag, ".cnt2"}, int'(bus2.match_count), m_cnt2);
    chk({tag, ".err"},  int'(bus8.cfg_err),     int'(m_err));
    chk({tag, ".k2"},   int'(bus2.state_out),   mk());
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    t_ld = 0; t_v = 0; t_clr = 0; t_b = 0;
  endtask

  task automatic feed(input bit b, input bit ov, input string tag);
    idle(); t_v = 1; t_b = b; t_ov = ov;
    tick(tag);
  endtask

  task automatic load(input bit [7:0] pat, input bit [3:0] len, input bit clr, input string tag);
    idle(); t_ld = 1; t_pat = pat; t_len = len; t_clr = clr;
    tick(tag);
  endtask

  initial begin
    bit [5:0] s1;
    bit [4:0] s3;
    reset = 1; idle(); t_ov = 1; t_pat = '0; t_len = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk) reset = 0;

    // Default 1010, overlapping
    s1 = 6'b101010;
    for (int i = 5; i >= 0; i--) feed(s1[i], 1, "ovl");
    chk("ovl_cnt", int'(bus8.match_count), 2);
    // Non-overlapping
    for (int i = 5; i >= 0; i--) feed(s1[i], 0, "novl");
    feed(1, 0, "novl"); feed(0, 0, "novl");
    chk("novl_k", int'(bus8.state_out), 4);

    // Pattern 1,1,0,1 with mismatch fallback
    load(8'b0000_1011, 4, 0, "ld1101");
    s3 = 5'b11101;
    for (int i = 4; i >= 0; i--) feed(s3[i], 1, "p1101");
    chk("p1101_det", int'(bus8.detected), 1);

    // Rejected loads keep old pattern; good load clears error
    load(8'hFF, 0, 0, "bad0");
    load(8'hFF, 9, 0, "bad9");
    chk("bad_err", int'(bus8.cfg_err), 1);
    for (int i = 4; i >= 0; i--) feed(s3[i], 1, "old_pat");
    load(8'h05, 4, 0, "good");
    chk("good_err", int'(bus8.cfg_err), 0);

    // len 1 saturation of the 2-bit counter, then clear against a match
    load(8'hF1, 1, 1, "ld1");
    for (int i = 0; i < 5; i++) feed(1, i[0], "sat");
    chk("sat_cnt2", int'(bus2.match_count), 3);
    idle(); t_v = 1; t_b = 1; t_clr = 1; tick("clr_hit");
    chk("clr_cnt2", int'(bus2.match_count), 0);

    // Asynchronous reset mid-sequence
    load(8'h05, 4, 0, "ld1010");
    feed(1, 1, "pre_rst"); feed(0, 1, "pre_rst"); feed(1, 1, "pre_rst");
    #2 reset = 1;
    #1 model_reset();
    check_all("rst_mid");
    #1 reset = 0;
    feed(0, 1, "post_rst");

    // Hold FULL with no valid data, then a load collides with a data bit
    s1 = 6'b001010;
    for (int i = 3; i >= 0; i--) feed(s1[i], 1, "to_full");
    for (int i = 0; i < 3; i++) begin idle(); tick("hold"); end
    chk("hold_det", int'(bus8.detected), 1);
    idle(); t_ld = 1; t_pat = 8'h05; t_len = 4; t_v = 1; t_b = 1; tick("ld_vs_data");
    chk("ld_vs_data_k", int'(bus8.state_out), 0);

    // Randomized traffic, biased toward completing the current pattern
    for (int n = 0; n < 800; n++) begin
      idle();
      t_ov  = ($urandom % 4) != 0;
      t_clr = ($urandom % 30) == 0;
      if (($urandom % 40) == 0) begin
        t_ld  = 1;
        t_pat = 8'($urandom);
        t_len = (($urandom % 5) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4));
      end
      t_v = ($urandom % 4) != 0;
      if (($urandom % 4) != 0 && mk() < m_len) t_b = m_pat[mk()];
      else t_b = 1'($urandom % 2);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
